// File: rtl/lcd_frame_build.sv
// Builds the 32-byte ASCII frame for the 16x2 LCD from BCD clock fields.
// Also drives the backlight enable with an inactivity timeout.
module lcd_frame_build #(
    parameter int BL_TIMEOUT = 10,
    parameter int BL_W       = 6
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic         sec_tick,
    input  logic         key_any,
    input  logic [15:0]  year,
    input  logic [7:0]   month,
    input  logic [7:0]   day,
    input  logic [7:0]   hour,
    input  logic [7:0]   minute,
    input  logic [2:0]   weekday,
    input  logic         alarm_on,
    input  logic         alarm_ring,
    input  logic [2:0]   edit_sel,
    output logic [255:0] data_out,
    output logic         bl_en
);

    localparam logic [BL_W-1:0] BL_INIT   = BL_W'(BL_TIMEOUT);
    localparam logic            BL_ALWAYS = (BL_TIMEOUT == 0);
    localparam logic [39:0]     ALARM_TXT = "Alarm";
    localparam logic [7:0]      SP        = 8'h20;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [2:0]  wday;
        logic        alarm_on;
        logic        ring;
        logic        phase;
        logic [2:0]  edit;
    } snap_t;

    snap_t           snap_q, snap_d;
    logic [2:0]      edit_sel_q, edit_sel_d;
    logic            phase_q, phase_d;
    logic            upd_q, upd_d;
    logic [BL_W-1:0] cnt_q, cnt_d;
    logic            bl_q, bl_d;
    logic [255:0]    data_q, data_d;
    logic [255:0]    img;
    logic            upd;

    function automatic logic [7:0] dig(input logic [3:0] n, input logic blank);
        logic [7:0] r;
        if (blank)
            r = SP;
        else if (n > 4'd9)
            r = 8'h3F;
        else
            r = {4'h3, n};
        return r;
    endfunction

    function automatic logic [71:0] wname(input logic [2:0] w);
        logic [71:0] r;
        unique case (w)
            3'd0: r = "Sunday   ";
            3'd1: r = "Monday   ";
            3'd2: r = "Tuesday  ";
            3'd3: r = "Wednesday";
            3'd4: r = "Thursday ";
            3'd5: r = "Friday   ";
            3'd6: r = "Saturday ";
            3'd7: r = "---------";
        endcase
        return r;
    endfunction

    always_comb begin
        upd        = sec_tick | key_any | (edit_sel != edit_sel_q);
        edit_sel_d = edit_sel;
        upd_d      = upd;
        phase_d    = phase_q;
        if (key_any)
            phase_d = 1'b0;
        else if (sec_tick)
            phase_d = ~phase_q;
        snap_d = snap_q;
        if (upd) begin
            snap_d.year     = year;
            snap_d.month    = month;
            snap_d.day      = day;
            snap_d.hour     = hour;
            snap_d.minute   = minute;
            snap_d.wday     = weekday;
            snap_d.alarm_on = alarm_on;
            snap_d.ring     = alarm_ring;
            snap_d.phase    = phase_d;
            snap_d.edit     = edit_sel;
        end
        cnt_d = cnt_q;
        if (key_any)
            cnt_d = BL_INIT;
        else if (sec_tick && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        bl_d   = BL_ALWAYS | (cnt_q != '0) | alarm_ring;
        data_d = upd_q ? img : data_q;
    end

    // Frame image is always derived from the snapshot; it is only latched one edge after capture.
    always_comb begin
        logic        ph, ed_act, show;
        logic [71:0] name;
        img    = {32{SP}};
        ph     = snap_q.phase;
        ed_act = (snap_q.edit >= 3'd1) && (snap_q.edit <= 3'd5);
        img[8*0  +: 8] = dig(snap_q.year[15:12], ph && snap_q.edit == 3'd1);
        img[8*1  +: 8] = dig(snap_q.year[11:8],  ph && snap_q.edit == 3'd1);
        img[8*2  +: 8] = dig(snap_q.year[7:4],   ph && snap_q.edit == 3'd1);
        img[8*3  +: 8] = dig(snap_q.year[3:0],   ph && snap_q.edit == 3'd1);
        img[8*4  +: 8] = 8'h2D;
        img[8*5  +: 8] = dig(snap_q.month[7:4],  ph && snap_q.edit == 3'd2);
        img[8*6  +: 8] = dig(snap_q.month[3:0],  ph && snap_q.edit == 3'd2);
        img[8*7  +: 8] = 8'h2D;
        img[8*8  +: 8] = dig(snap_q.day[7:4],    ph && snap_q.edit == 3'd3);
        img[8*9  +: 8] = dig(snap_q.day[3:0],    ph && snap_q.edit == 3'd3);
        img[8*11 +: 8] = dig(snap_q.hour[7:4],   ph && snap_q.edit == 3'd4);
        img[8*12 +: 8] = dig(snap_q.hour[3:0],   ph && snap_q.edit == 3'd4);
        img[8*13 +: 8] = (ph && !ed_act) ? SP : 8'h3A;
        img[8*14 +: 8] = dig(snap_q.minute[7:4], ph && snap_q.edit == 3'd5);
        img[8*15 +: 8] = dig(snap_q.minute[3:0], ph && snap_q.edit == 3'd5);
        name = wname(snap_q.wday);
        for (int i = 0; i < 9; i++)
            img[8*(16+i) +: 8] = name[8*(8-i) +: 8];
        show = snap_q.ring ? ~ph : snap_q.alarm_on;
        for (int i = 0; i < 5; i++)
            img[8*(27+i) +: 8] = show ? ALARM_TXT[8*(4-i) +: 8] : SP;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            snap_q     <= '0;
            edit_sel_q <= '0;
            phase_q    <= 1'b0;
            upd_q      <= 1'b0;
            cnt_q      <= BL_INIT;
            bl_q       <= 1'b1;
            data_q     <= {32{SP}};
        end else begin
            snap_q     <= snap_d;
            edit_sel_q <= edit_sel_d;
            phase_q    <= phase_d;
            upd_q      <= upd_d;
            cnt_q      <= cnt_d;
            bl_q       <= bl_d;
            data_q     <= data_d;
        end
    end

    assign data_out = data_q;
    assign bl_en    = bl_q;

endmodule

// File: tb/tb_lcd_frame_build.sv
// Bench for lcd_frame_build: directed scenarios plus random traffic
// against a string-level model of the LCD frame.
module tb_lcd_frame_build;

    localparam int BLT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sec_tick = 1'b0, key_any = 1'b0;
    logic [15:0]  year = '0;
    logic [7:0]   month = '0, day = '0, hour = '0, minute = '0;
    logic [2:0]   weekday = '0, edit_sel = '0;
    logic         alarm_on = 1'b0, alarm_ring = 1'b0;
    logic [255:0] data_out;
    logic         bl_en;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    lcd_frame_build #(.BL_TIMEOUT(BLT), .BL_W(6)) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .sec_tick(sec_tick), .key_any(key_any),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .weekday(weekday), .alarm_on(alarm_on), .alarm_ring(alarm_ring),
        .edit_sel(edit_sel), .data_out(data_out), .bl_en(bl_en)
    );

    string names[8] = '{"Sunday   ", "Monday   ", "Tuesday  ", "Wednesday",
                        "Thursday ", "Friday   ", "Saturday ", "---------"};

    // model state
    logic         m_phase, m_bl, m_pend;
    int           m_cnt;
    logic [2:0]   m_editq;
    logic [255:0] m_frame;
    logic [15:0]  s_year;
    logic [7:0]   s_month, s_day, s_hour, s_minute;
    logic [2:0]   s_wday, s_edit;
    logic         s_alon, s_ring, s_phase;

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_txt(string tag, int first, string s);
        logic [255:0] g = '0;
        logic [255:0] e = '0;
        for (int i = 0; i < s.len(); i++) begin
            g[8*i +: 8] = data_out[8*(first+i) +: 8];
            e[8*i +: 8] = s[i];
        end
        chk(tag, g, e);
    endtask

    function automatic logic [7:0] dch(logic [3:0] n);
        return (n > 9) ? 8'h3F : 8'h30 + 8'(n);
    endfunction

    function automatic logic [255:0] build();
        byte unsigned b[32];
        logic [255:0] r;
        bit ed;
        bit show;
        string nm;
        for (int k = 0; k < 32; k++) b[k] = " ";
        ed = (s_edit >= 1 && s_edit <= 5);
        b[0] = dch(s_year[15:12]); b[1] = dch(s_year[11:8]);
        b[2] = dch(s_year[7:4]);   b[3] = dch(s_year[3:0]);
        b[4] = "-";
        b[5] = dch(s_month[7:4]);  b[6] = dch(s_month[3:0]);
        b[7] = "-";
        b[8] = dch(s_day[7:4]);    b[9] = dch(s_day[3:0]);
        b[11] = dch(s_hour[7:4]);  b[12] = dch(s_hour[3:0]);
        b[13] = (s_phase && !ed) ? " " : ":";
        b[14] = dch(s_minute[7:4]); b[15] = dch(s_minute[3:0]);
        if (s_phase) begin
            case (s_edit)
                1: for (int k = 0; k <= 3; k++) b[k] = " ";
                2: begin b[5] = " "; b[6] = " "; end
                3: begin b[8] = " "; b[9] = " "; end
                4: begin b[11] = " "; b[12] = " "; end
                5: begin b[14] = " "; b[15] = " "; end
                default: ;
            endcase
        end
        nm = names[s_wday];
        for (int i = 0; i < 9; i++) b[16+i] = nm[i];
        show = s_ring ? !s_phase : s_alon;
        if (show) begin
            b[27] = "A"; b[28] = "l"; b[29] = "a"; b[30] = "r"; b[31] = "m";
        end
        for (int k = 0; k < 32; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_cnt = BLT; m_bl = 1; m_editq = 0; m_pend = 0;
        m_frame = {32{8'h20}};
        s_year = 0; s_month = 0; s_day = 0; s_hour = 0; s_minute = 0;
        s_wday = 0; s_edit = 0; s_alon = 0; s_ring = 0; s_phase = 0;
    endtask

    task automatic m_step();
        bit upd;
        bit nph;
        if (m_pend) m_frame = build();
        upd = sec_tick || key_any || (edit_sel != m_editq);
        nph = key_any ? 1'b0 : (sec_tick ? !m_phase : m_phase);
        if (upd) begin
            s_year = year; s_month = month; s_day = day; s_hour = hour;
            s_minute = minute; s_wday = weekday; s_alon = alarm_on;
            s_ring = alarm_ring; s_phase = nph; s_edit = edit_sel;
        end
        m_pend = upd;
        m_bl = (BLT == 0) || (m_cnt != 0) || alarm_ring;
        if (key_any) m_cnt = BLT;
        else if (sec_tick && m_cnt > 0) m_cnt = m_cnt - 1;
        m_phase = nph;
        m_editq = edit_sel;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        chk("frame", data_out, m_frame);
        chk("bl_en", bl_en, m_bl);
        sec_tick = 0;
        key_any = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        m_reset();
        chk("rst_frame", data_out, {32{8'h20}});
        chk("rst_bl", bl_en, 1'b1);
        #3;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        #2;
        do_reset();
        cyc(); cyc();
        chk("hold_frame", data_out, {32{8'h20}});

        year = 16'h2024; month = 8'h03; day = 8'h15; hour = 8'h09;
        minute = 8'h07; weekday = 3;
        key_any = 1; cyc(); cyc();
        chk_txt("line1", 0, "2024-03-15 09:07");
        chk_txt("wed", 16, "Wednesday");
        sec_tick = 1; cyc(); cyc();
        chk_txt("colon_off", 0, "2024-03-15 09 07");

        minute = 8'h7A; weekday = 7;
        key_any = 1; cyc(); cyc();
        chk_txt("min_bad", 14, "7?");
        chk_txt("wday7", 16, "---------");

        edit_sel = 4; cyc(); cyc();
        chk_txt("edit_on", 11, "09:");
        sec_tick = 1; cyc(); cyc();
        chk_txt("edit_blank", 11, "  :");
        sec_tick = 1; cyc(); cyc();
        chk_txt("edit_show", 11, "09:");
        sec_tick = 1; cyc(); cyc();
        chk_txt("edit_blank2", 11, "  :");
        key_any = 1; cyc(); cyc();
        chk_txt("edit_key", 11, "09:");

        edit_sel = 0; alarm_on = 1; cyc(); cyc();
        chk_txt("alarm", 27, "Alarm");
        sec_tick = 1; cyc(); cyc();
        chk_txt("alarm_steady", 27, "Alarm");

        key_any = 1; cyc(); cyc();
        sec_tick = 1; cyc(); cyc();
        sec_tick = 1; cyc(); cyc();
        sec_tick = 1; cyc();
        chk("bl_t3", bl_en, 1'b1);
        cyc();
        chk("bl_off", bl_en, 1'b0);

        key_any = 1; cyc(); cyc();
        sec_tick = 1; cyc(); cyc();
        sec_tick = 1; cyc(); cyc();
        sec_tick = 1; key_any = 1; cyc(); cyc();
        chk("bl_reload", bl_en, 1'b1);
        cyc(); cyc(); cyc();
        chk("bl_hold", bl_en, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1; cyc(); cyc();
        end
        cyc();
        chk("bl_off2", bl_en, 1'b0);

        alarm_ring = 1; cyc(); cyc();
        chk("bl_ring", bl_en, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1; cyc(); cyc();
            chk_txt("ring_blink", 27, m_phase ? "     " : "Alarm");
            chk("bl_ring_hold", bl_en, 1'b1);
        end
        alarm_ring = 0;

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            sec_tick = ($urandom_range(0, 5) == 0);
            key_any = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) edit_sel = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                year = 16'($urandom); month = 8'($urandom);
                day = 8'($urandom); hour = 8'($urandom);
                minute = 8'($urandom); weekday = 3'($urandom);
            end
            if ($urandom_range(0, 24) == 0) alarm_on = ~alarm_on;
            if ($urandom_range(0, 39) == 0) alarm_ring = ~alarm_ring;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
